// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter and sequencer sharing one UART transmitter among NUM_REQ byte-stream
//   requesters. A winning byte is latched on its valid/ready handshake, the transmitter gets a
//   one-cycle tx_dv, the arbiter waits for tx_done (optionally guarded by a watchdog), inserts
//   an optional gap, then re-arbitrates.
//
//   Optional feature macro: UART_ARB_PACKET_LOCK_EN
//     When defined, accepting a byte with req_last=0 locks the grant to that requester until a
//     byte with req_last=1 is accepted, a watchdog abort occurs, or reset.
//     When undefined, req_last is ignored and every byte is re-arbitrated.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_byte    per-requester byte offer; byte i at req_byte[8i+7:8i]
//   req_last              last byte of packet (packet-lock builds only)
//   req_ready             one-hot accept strobe, only ever set in idle
//   tx_dv/tx_byte         start pulse and byte to the transmitter
//   tx_active/tx_done     transmitter busy status and one-cycle completion pulse
//   grant_id              index of most recently accepted requester
//   busy                  arbiter not idle or transmitter active
//   timeout_err           one-cycle pulse when the watchdog aborts a transfer
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned GAP_CYCLES     = 0,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_byte,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_dv,
    output logic [7:0]                 tx_byte,
    input  logic                       tx_active,
    input  logic                       tx_done,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam int unsigned IdW = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ReqOne = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef logic [IdW-1:0] id_t;

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StWaitDone,
        StGap
    } state_e;

    state_e      state_q, state_d;
    id_t         last_grant_q, last_grant_d;
    id_t         grant_id_q, grant_id_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic [15:0] wdog_q, wdog_d;
    logic [7:0]  gap_q, gap_d;

`ifdef UART_ARB_PACKET_LOCK_EN
    logic lock_q, lock_d;
    id_t  lock_id_q, lock_id_d;
`else
    logic unused_req_last;
    assign unused_req_last = ^req_last;
`endif

    logic [NUM_REQ-1:0] eligible;
    id_t                winner;
    logic               any_valid;
    logic               wdog_expire;
    logic               gap_expire;
    state_e             after_done;

    // Round-robin pick: first eligible requester scanning upward from last_grant+1 with wrap.
    always_comb begin
        eligible = req_valid;
`ifdef UART_ARB_PACKET_LOCK_EN
        if (lock_q) begin
            eligible = req_valid & (ReqOne << lock_id_q);
        end
`endif
        winner    = '0;
        any_valid = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            if (!any_valid && eligible[id_t'((32'(last_grant_q) + k) % NUM_REQ)]) begin
                winner    = id_t'((32'(last_grant_q) + k) % NUM_REQ);
                any_valid = 1'b1;
            end
        end
    end

    // Watchdog fires in the cycle that is TIMEOUT_CYCLES after the tx_dv cycle.
    assign wdog_expire = (17'(wdog_q) + 17'd1) >= 17'(TIMEOUT_CYCLES);
    assign gap_expire  = (9'(gap_q) + 9'd1) >= 9'(GAP_CYCLES);
    assign after_done  = (GAP_CYCLES != 0) ? StGap : StIdle;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        tx_byte_d    = tx_byte_q;
        wdog_d       = wdog_q;
        gap_d        = gap_q;
        req_ready    = '0;
        tx_dv        = 1'b0;
        timeout_err  = 1'b0;
`ifdef UART_ARB_PACKET_LOCK_EN
        lock_d       = lock_q;
        lock_id_d    = lock_id_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (any_valid) begin
                    req_ready  = ReqOne << winner;
                    tx_byte_d  = req_byte[{winner, 3'b000} +: 8];
                    grant_id_d = winner;
`ifdef UART_ARB_PACKET_LOCK_EN
                    // Pointer only moves when a packet ends, so a locked stream keeps priority.
                    if (req_last[winner]) begin
                        lock_d       = 1'b0;
                        last_grant_d = winner;
                    end else begin
                        lock_d    = 1'b1;
                        lock_id_d = winner;
                    end
`else
                    last_grant_d = winner;
`endif
                    state_d = StLaunch;
                end
            end

            StLaunch: begin
                tx_dv   = 1'b1;
                wdog_d  = '0;
                state_d = StWaitDone;
            end

            StWaitDone: begin
                // tx_done wins over a coincident watchdog expiry.
                if (tx_done) begin
                    gap_d   = '0;
                    state_d = after_done;
                end else if ((TIMEOUT_CYCLES != 0) && wdog_expire) begin
                    timeout_err = 1'b1;
                    gap_d       = '0;
                    state_d     = after_done;
`ifdef UART_ARB_PACKET_LOCK_EN
                    if (lock_q) begin
                        lock_d       = 1'b0;
                        last_grant_d = lock_id_q;
                    end
`endif
                end else if (wdog_q != 16'hFFFF) begin
                    wdog_d = wdog_q + 16'd1;
                end
            end

            StGap: begin
                if (gap_expire) begin
                    state_d = StIdle;
                end else if (gap_q != 8'hFF) begin
                    gap_d = gap_q + 8'd1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            last_grant_q <= id_t'(NUM_REQ - 1);
            grant_id_q   <= '0;
            tx_byte_q    <= '0;
            wdog_q       <= '0;
            gap_q        <= '0;
`ifdef UART_ARB_PACKET_LOCK_EN
            lock_q       <= 1'b0;
            lock_id_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            tx_byte_q    <= tx_byte_d;
            wdog_q       <= wdog_d;
            gap_q        <= gap_d;
`ifdef UART_ARB_PACKET_LOCK_EN
            lock_q       <= lock_d;
            lock_id_q    <= lock_id_d;
`endif
        end
    end

    assign tx_byte  = tx_byte_q;
    assign grant_id = grant_id_q;
    assign busy     = (state_q != StIdle) || tx_active;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: NUM_REQ=4, GAP_CYCLES=3, TIMEOUT_CYCLES=20.
// Requesters and transmitter are modelled in the bench; expected grants come from a
// round-robin model over pending-request arrays.
module tb_uart_tx_arbiter;

    localparam int unsigned NR  = 4;
    localparam int unsigned GAP = 3;
    localparam int unsigned TO  = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_byte;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic        tx_active;
    logic        tx_done;
    logic [1:0]  grant_id;
    logic        busy;
    logic        timeout_err;

    uart_tx_arbiter #(
        .NUM_REQ        (NR),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_byte    (req_byte),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_dv       (tx_dv),
        .tx_byte     (tx_byte),
        .tx_active   (tx_active),
        .tx_done     (tx_done),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int dv_count = 0;
    int n_launch = 0;

    // Reference model state
    bit         pend [4];
    logic [7:0] mbyte[4];
    bit         mlast[4];
    int         last_g;
    bit         locked;
    int         lock_id;
    int         order_q[$];

    always @(posedge clk) if (tx_dv === 1'b1) dv_count++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < 4; i++) begin
            req_valid[i]       = pend[i];
            req_byte[8*i +: 8] = mbyte[i];
            req_last[i]        = mlast[i];
        end
        #1;
    endtask

    task automatic model_reset();
        last_g = 3;
        locked = 1'b0;
        lock_id = 0;
        for (int i = 0; i < 4; i++) begin
            pend[i]  = 1'b0;
            mbyte[i] = 8'h00;
            mlast[i] = 1'b1;
        end
        drive_inputs();
    endtask

    function automatic int pick();
        if (locked) return pend[lock_id] ? lock_id : -1;
        for (int k = 1; k <= 4; k++) begin
            if (pend[(last_g + k) % 4]) return (last_g + k) % 4;
        end
        return -1;
    endfunction

    function automatic void accept(input int w);
        pend[w] = 1'b0;
`ifdef UART_ARB_PACKET_LOCK_EN
        if (mlast[w]) begin
            locked = 1'b0;
            last_g = w;
        end else begin
            locked  = 1'b1;
            lock_id = w;
        end
`else
        last_g = w;
`endif
    endfunction

    function automatic void model_timeout();
`ifdef UART_ARB_PACKET_LOCK_EN
        if (locked) begin
            locked = 1'b0;
            last_g = lock_id;
        end
`endif
    endfunction

    function automatic int count_in_order(input int who);
        int n = 0;
        foreach (order_q[i]) if (order_q[i] == who) n++;
        return n;
    endfunction

    // mode 0: random arrivals; 1: all valid, single-byte packets; 2: packet scenario; 3: none
    task automatic refill(input int mode);
        int n1;
        case (mode)
            0: begin
                for (int i = 0; i < 4; i++) begin
                    if (!pend[i] && $urandom_range(1, 0) == 1) begin
                        pend[i]  = 1'b1;
                        mbyte[i] = 8'($urandom);
                        mlast[i] = 1'($urandom);
                    end
                end
                if (locked && !pend[lock_id]) begin
                    pend[lock_id]  = 1'b1;
                    mbyte[lock_id] = 8'($urandom);
                    mlast[lock_id] = 1'($urandom);
                end
                if (!(pend[0] || pend[1] || pend[2] || pend[3])) begin
                    n1 = int'($urandom_range(3, 0));
                    pend[n1]  = 1'b1;
                    mbyte[n1] = 8'($urandom);
                    mlast[n1] = 1'b1;
                end
            end
            1: begin
                for (int i = 0; i < 4; i++) begin
                    if (!pend[i]) begin
                        pend[i]  = 1'b1;
                        mbyte[i] = 8'($urandom);
                        mlast[i] = 1'b1;
                    end
                end
            end
            2: begin
                n1 = count_in_order(1);
                if (!pend[1] && n1 < 3) begin
                    pend[1]  = 1'b1;
                    mbyte[1] = 8'($urandom);
                    mlast[1] = (n1 == 2);
                end
                if (!pend[2]) begin
                    pend[2]  = 1'b1;
                    mbyte[2] = 8'($urandom);
                    mlast[2] = 1'b1;
                end
            end
            default: ;
        endcase
        drive_inputs();
    endtask

    // One full transaction starting in an idle cycle; returns in the next idle cycle.
    task automatic xfer(input int d, input bit do_timeout, input int mode);
        int         w;
        logic [7:0] b;
        logic [3:0] exp_ready;
        #1;
        w = pick();
        exp_ready = (w < 0) ? 4'd0 : 4'(1 << w);
        chk("accept_ready", 32'(req_ready), 32'(exp_ready));
        if (w < 0) w = 0;
        b = mbyte[w];
        step();
        chk("launch_dv", 32'(tx_dv), 32'd1);
        chk("launch_byte", 32'(tx_byte), 32'(b));
        chk("launch_grant", 32'(grant_id), 32'(w));
        n_launch++;
        order_q.push_back(w);
        accept(w);
        drive_inputs();
        tx_active = 1'b1;
        tx_done   = 1'($urandom);  // stray done during launch must be ignored
        if (do_timeout) begin
            for (int c = 1; c < int'(TO); c++) begin
                step();
                tx_done = 1'b0;
            end
            chk("pre_timeout", 32'(timeout_err), 32'd0);
            step();
            chk("timeout_pulse", 32'(timeout_err), 32'd1);
            model_timeout();
            step();
        end else begin
            for (int c = 1; c <= d; c++) begin
                step();
                tx_done = 1'b0;
                if (c == 1) chk("dv_one_cycle", 32'(tx_dv), 32'd0);
            end
            tx_done = 1'b1;
            #1;
            chk("no_timeout_on_done", 32'(timeout_err), 32'd0);
            step();
            tx_done = 1'b0;
        end
        tx_active = 1'b0;
        refill(mode);
        chk("gap_busy", 32'(busy), 32'd1);
        for (int g = 0; g < int'(GAP); g++) begin
            chk("gap_ready", 32'(req_ready), 32'd0);
            tx_done = 1'($urandom);
            step();
            tx_done = 1'b0;
        end
    endtask

    int exp_pkt[4];
    int exp_rr[5];
    int dv_before;

    initial begin
`ifdef UART_ARB_PACKET_LOCK_EN
        exp_pkt = '{1, 1, 1, 2};
`else
        exp_pkt = '{1, 2, 1, 2};
`endif
        exp_rr = '{0, 1, 2, 3, 0};

        reset     = 1'b1;
        req_valid = '0;
        req_byte  = '0;
        req_last  = '0;
        tx_active = 1'b0;
        tx_done   = 1'b0;
        repeat (3) step();
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_dv", 32'(tx_dv), 32'd0);
        chk("rst_byte", 32'(tx_byte), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);
        reset = 1'b0;
        model_reset();
        step();

        tx_active = 1'b1;
        #1;
        chk("busy_from_tx_active", 32'(busy), 32'd1);
        tx_active = 1'b0;
        #1;
        chk("idle_not_busy", 32'(busy), 32'd0);

        // Single requester 0 with 0x55
        pend[0]  = 1'b1;
        mbyte[0] = 8'h55;
        mlast[0] = 1'b1;
        drive_inputs();
        chk("first_ready", 32'(req_ready), 32'h1);
        xfer(10, 1'b0, 3);
        chk("first_byte_held", 32'(tx_byte), 32'h55);

        // Reset while waiting for done; a late done after release must be ignored
        pend[2]  = 1'b1;
        mbyte[2] = 8'hA7;
        mlast[2] = 1'b1;
        drive_inputs();
        chk("pre_reset_ready", 32'(req_ready), 32'h4);
        step();
        chk("pre_reset_dv", 32'(tx_dv), 32'd1);
        n_launch++;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_reset();
        dv_before = dv_count;
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("late_done_dv", 32'(tx_dv), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_byte", 32'(tx_byte), 32'd0);
        chk("post_rst_grant", 32'(grant_id), 32'd0);
        chk("post_rst_ready", 32'(req_ready), 32'd0);
        step();
        chk("late_done_no_launch", 32'(dv_count - dv_before), 32'd0);

        // All four valid continuously: 0,1,2,3,0
        order_q.delete();
        dv_before = dv_count;
        refill(1);
        for (int t = 0; t < 5; t++) xfer(10, 1'b0, 1);
        for (int t = 0; t < 5; t++) chk("rr_order", 32'(order_q[t]), 32'(exp_rr[t]));
        chk("dv_per_done", 32'(dv_count - dv_before), 32'd5);

        // Watchdog abort, then next requester; then done exactly at the expiry cycle
        xfer(0, 1'b1, 1);
        chk("timeout_grant", 32'(order_q[5]), 32'd1);
        xfer(20, 1'b0, 1);
        chk("after_timeout_grant", 32'(grant_id), 32'd2);

        // Packet scenario: requester 1 sends three bytes while requester 2 stays valid
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_reset();
        order_q.delete();
        pend[1]  = 1'b1;
        mbyte[1] = 8'h11;
        mlast[1] = 1'b0;
        pend[2]  = 1'b1;
        mbyte[2] = 8'h22;
        mlast[2] = 1'b1;
        drive_inputs();
        for (int t = 0; t < 4; t++) xfer(int'($urandom_range(19, 1)), 1'b0, 2);
        for (int t = 0; t < 4; t++) chk("pkt_order", 32'(order_q[t]), 32'(exp_pkt[t]));

        // Randomised traffic
        refill(0);
        for (int t = 0; t < 25; t++) begin
            xfer(int'($urandom_range(20, 1)), ($urandom_range(7, 0) == 0), 0);
        end
        step();
        chk("total_launches", 32'(dv_count), 32'(n_launch));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
